// File: rtl/fifo_pkg.sv
// Shared types for the dual-clock FIFO and its stream-side clients.
// The stream word pairs a FIFO data word with a frame-boundary flag.
package fifo_pkg;

  localparam int W_DATA_DEF    = 8;
  localparam int FRAME_LEN_DEF = 16;
  localparam int W_CNT_DEF     = 16;

  typedef logic [W_DATA_DEF-1:0] data_t;
  typedef logic [W_CNT_DEF-1:0]  wcnt_t;

  typedef struct packed {
    data_t data;
    logic  last;
  } stream_word_t;

  // Occupancy of a 2-entry buffer after one cycle of writes and reads.
  function automatic logic [1:0] occ_after(input logic [1:0] occ,
                                           input logic       wr,
                                           input logic       rd);
    logic [1:0] result;
    result = occ;
    if (wr && !rd) begin
      result = occ + 2'd1;
    end else if (rd && !wr) begin
      result = occ - 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_skid_buf2.sv
// Two-entry stream_word_t buffer with valid/ready handshakes on both sides.
// The read side is driven only from registered state, so rd_valid never depends on rd_ready.
module fifo_skid_buf2
  import fifo_pkg::*;
(
  input  logic         clk,
  input  logic         srst,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  stream_word_t wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output stream_word_t rd_data,
  output logic [1:0]   occ
);

  stream_word_t mem_reg [2];
  logic         head_reg;
  logic         tail_reg;
  logic [1:0]   occ_reg;
  logic [1:0]   occ_next;
  logic         wr_en;
  logic         rd_en;

  assign rd_valid = (occ_reg != 2'd0);
  assign rd_en    = rd_valid & rd_ready;
  // A full buffer can still take a word in the cycle its head leaves.
  assign wr_ready = (occ_reg != 2'd2) | rd_en;
  assign wr_en    = wr_valid & wr_ready;
  assign rd_data  = mem_reg[head_reg];
  assign occ      = occ_reg;

  always_comb begin
    occ_next = occ_after(occ_reg, wr_en, rd_en);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (srst) begin
          mem_reg[gi] <= '0;
        end else if (wr_en && (tail_reg == 1'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      head_reg <= 1'b0;
      tail_reg <= 1'b0;
      occ_reg  <= 2'd0;
    end else begin
      if (rd_en) begin
        head_reg <= ~head_reg;
      end
      if (wr_en) begin
        tail_reg <= ~tail_reg;
      end
      occ_reg <= occ_next;
    end
  end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side FIFO client: issues pops, absorbs the one-cycle read latency and
// re-presents words as a valid/ready stream with frame marking and a delivered-word count.
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int W_DATA    = W_DATA_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int W_CNT     = W_CNT_DEF
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [W_DATA-1:0] fifo_data_out,
  output logic              fifo_pop,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [W_DATA-1:0] m_data,
  output logic              m_last,
  output logic [W_CNT-1:0]  words_out,
  output logic              idle
);

  localparam int W_IDX = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [W_IDX-1:0] IDX_LAST = W_IDX'(FRAME_LEN - 1);

  logic             inflight_reg;
  logic [W_IDX-1:0] idx_reg;
  logic [W_IDX-1:0] idx_next;
  logic [W_CNT-1:0] words_reg;
  logic [W_CNT-1:0] words_next;
  logic [1:0]       occ;
  logic [2:0]       load;
  logic             fire;
  logic             accept;
  logic             capture;
  logic             buf_wr_ready;
  stream_word_t     word_in;
  stream_word_t     word_out;

  assign fire = m_valid & m_ready;

  // Words already committed (buffered or arriving next cycle) minus the one leaving now.
  assign load     = {1'b0, occ} + {2'b00, inflight_reg} - {2'b00, fire};
  assign fifo_pop = en & ~fifo_empty & (load < 3'd2);
  assign accept   = fifo_pop & ~fifo_empty;

  // FIFO read data is valid exactly one cycle after an accepted pop.
  assign capture      = inflight_reg;
  assign word_in.data = data_t'(fifo_data_out);
  assign word_in.last = (idx_reg == IDX_LAST);

  fifo_skid_buf2 u_buf (
    .clk      (rd_clk),
    .srst     (rd_rst),
    .wr_valid (capture),
    .wr_ready (buf_wr_ready),
    .wr_data  (word_in),
    .rd_valid (m_valid),
    .rd_ready (m_ready),
    .rd_data  (word_out),
    .occ      (occ)
  );

  assign m_data    = W_DATA'(word_out.data);
  assign m_last    = word_out.last;
  assign words_out = words_reg;
  assign idle      = (occ == 2'd0) & ~inflight_reg;

  always_comb begin
    idx_next = idx_reg;
    if (capture) begin
      idx_next = word_in.last ? '0 : idx_reg + 1'b1;
    end
  end

  always_comb begin
    words_next = words_reg;
    if (fire && (words_reg != '1)) begin
      words_next = words_reg + 1'b1;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      inflight_reg <= 1'b0;
      idx_reg      <= '0;
      words_reg    <= '0;
    end else begin
      inflight_reg <= accept;
      idx_reg      <= idx_next;
      words_reg    <= words_next;
    end
  end

  // Pop throttling must keep committed words within the two buffer slots.
  a_no_overflow : assert property (@(posedge rd_clk) disable iff (rd_rst)
    ({1'b0, occ} + {2'b00, inflight_reg}) <= 3'd2);

  a_capture_room : assert property (@(posedge rd_clk) disable iff (rd_rst)
    capture |-> buf_wr_ready);

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed plus randomized bench for fifo_rd_stream_adapter against a FIFO model and
// an in-order scoreboard; a second instance with FRAME_LEN=1 runs on the same inputs.
module tb_fifo_rd_stream_adapter;

  localparam int DEPTH = 16384;

  logic       clk = 1'b0;
  logic       rd_rst = 1'b1;
  logic       en = 1'b0;
  logic       m_ready = 1'b0;
  logic       stall = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data_out = 8'h00;

  logic       fifo_pop, m_valid, m_last, idle;
  logic [7:0] m_data;
  logic [3:0] words_out;
  logic       fifo_pop_b, m_valid_b, m_last_b, idle_b;
  logic [7:0] m_data_b;
  logic [15:0] words_out_b;

  logic [7:0] fifo_mem [DEPTH];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] pend [$];

  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   exp_ptr = 0;
  int   n_del = 0;
  logic prev_hold = 1'b0;
  logic acc_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic prev_last = 1'b0;
  int   first_pop, first_valid, first_fire, last_fire;
  int   n_pop_win, n_fire_win, n_last_win;
  int   soak_pushed;

  always #5 clk = ~clk;

  assign fifo_empty = stall || (wr_ptr == rd_ptr);

  // Behavioural FIFO: registered read data one cycle after an accepted pop.
  always @(posedge clk) begin
    if (rd_rst) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_pop && !fifo_empty) begin
      fifo_data_out <= fifo_mem[rd_ptr % DEPTH];
      rd_ptr <= rd_ptr + 1;
    end
  end

  fifo_rd_stream_adapter #(.W_DATA(8), .FRAME_LEN(4), .W_CNT(4)) dut (
    .rd_clk(clk), .rd_rst(rd_rst), .en(en), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_pop(fifo_pop), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .words_out(words_out), .idle(idle)
  );

  fifo_rd_stream_adapter #(.W_DATA(8), .FRAME_LEN(1), .W_CNT(16)) dut_b (
    .rd_clk(clk), .rd_rst(rd_rst), .en(en), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_pop(fifo_pop_b), .m_valid(m_valid_b),
    .m_ready(m_ready), .m_data(m_data_b), .m_last(m_last_b),
    .words_out(words_out_b), .idle(idle_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] d);
    pend.push_back(d);
  endtask

  task automatic clr_win();
    first_pop = -1; first_valid = -1; first_fire = -1; last_fire = -1;
    n_pop_win = 0; n_fire_win = 0; n_last_win = 0;
  endtask

  // One clock cycle: apply inputs after the falling edge, then check and score.
  task automatic cycle(input logic en_i, input logic rdy_i, input logic stall_i);
    logic pop_now, fire_now;
    int   sat;
    @(negedge clk);
    while (pend.size() > 0) begin
      fifo_mem[wr_ptr % DEPTH] = pend.pop_front();
      wr_ptr++;
    end
    en = en_i; m_ready = rdy_i; stall = stall_i;
    #1;
    pop_now  = fifo_pop && !fifo_empty;
    fire_now = m_valid && m_ready;
    sat = (n_del > 15) ? 15 : n_del;
    chk("words_out", 32'(words_out), 32'(sat));
    chk("words_out_b", 32'(words_out_b), 32'(n_del));
    chk("idle", 32'(idle), 32'(!m_valid && !acc_prev));
    chk("mirror_b", 32'({fifo_pop_b, m_valid_b, m_data_b, idle_b}),
        32'({fifo_pop, m_valid, m_data, idle}));
    if (m_valid_b) chk("last_b", 32'(m_last_b), 32'd1);
    if (prev_hold) chk("hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, prev_last, prev_data}));
    chk("held_le2", 32'((rd_ptr - exp_ptr + int'(pop_now) - int'(fire_now)) <= 2), 32'd1);
    if (pop_now) begin
      n_pop_win++;
      if (first_pop < 0) first_pop = cyc;
    end
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (fire_now) begin
      chk("data", 32'(m_data), 32'(fifo_mem[exp_ptr % DEPTH]));
      chk("last", 32'(m_last), 32'((n_del % 4) == 3));
      if (m_last) n_last_win++;
      n_fire_win++;
      if (first_fire < 0) first_fire = cyc;
      last_fire = cyc;
      exp_ptr++;
      n_del++;
    end
    prev_hold = m_valid && !m_ready;
    prev_data = m_data;
    prev_last = m_last;
    acc_prev  = pop_now;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (!(exp_ptr == wr_ptr && idle && pend.size() == 0) && k < budget) begin
      cycle(1'b1, 1'b1, 1'b0);
      k++;
    end
    chk("drain_done", 32'(exp_ptr == wr_ptr && idle), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rd_rst = 1'b1; en = 1'b0; m_ready = 1'b0; stall = 1'b0;
    @(posedge clk);
    exp_ptr = wr_ptr;
    n_del = 0;
    @(negedge clk);
    rd_rst = 1'b0;
    #1;
    prev_hold = 1'b0;
    acc_prev = 1'b0;
    chk("rst_pop", 32'(fifo_pop), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_words", 32'(words_out), 32'd0);
    chk("rst_words_b", 32'(words_out_b), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
  endtask

  initial begin
    do_reset();

    // Streaming 0x01..0x05 at full rate.
    clr_win();
    for (int i = 1; i <= 5; i++) push(8'(i));
    drain(30);
    chk("t1_latency", 32'(first_valid - first_pop), 32'd2);
    chk("t1_pops", 32'(n_pop_win), 32'd5);
    chk("t1_fires", 32'(n_fire_win), 32'd5);
    chk("t1_back_to_back", 32'(last_fire - first_fire), 32'd4);
    chk("t1_words", 32'(words_out), 32'd5);
    chk("t1_idle", 32'(idle), 32'd1);

    // Backpressure: only two words may be committed.
    clr_win();
    for (int i = 0; i < 8; i++) push(8'($urandom));
    repeat (10) cycle(1'b1, 1'b0, 1'b0);
    chk("t2_accepts", 32'(n_pop_win), 32'd2);
    chk("t2_pop_off", 32'(fifo_pop), 32'd0);
    chk("t2_head", 32'({m_valid, m_data}), 32'({1'b1, fifo_mem[exp_ptr % DEPTH]}));
    drain(40);
    chk("t2_fires", 32'(n_fire_win), 32'd8);
    chk("t2_words", 32'(words_out), 32'd13);

    // Frame marking with FRAME_LEN=4.
    do_reset();
    clr_win();
    for (int i = 0; i < 10; i++) push(8'($urandom));
    drain(40);
    chk("t3_lasts", 32'(n_last_win), 32'd2);
    clr_win();
    push(8'($urandom));
    push(8'($urandom));
    drain(20);
    chk("t3_next_frame", 32'(n_last_win), 32'd1);

    // en dropped right after an accept.
    clr_win();
    for (int i = 0; i < 4; i++) push(8'($urandom));
    cycle(1'b1, 1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b1, 1'b0);
    chk("t4_one_pop", 32'(n_pop_win), 32'd1);
    chk("t4_inflight_out", 32'(n_fire_win), 32'd1);
    drain(30);
    chk("t4_resumed", 32'(n_fire_win), 32'd4);

    // Reset with two words held.
    for (int i = 0; i < 4; i++) push(8'($urandom));
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    chk("t5_held", 32'(rd_ptr - exp_ptr), 32'd2);
    do_reset();
    clr_win();
    for (int i = 0; i < 5; i++) push(8'($urandom));
    drain(30);
    chk("t5_fires", 32'(n_fire_win), 32'd5);
    chk("t5_fresh_frame", 32'(n_last_win), 32'd1);

    // Counter saturation.
    clr_win();
    for (int i = 0; i < 20; i++) push(8'($urandom));
    drain(60);
    chk("t6_saturate", 32'(words_out), 32'd15);
    chk("t6_words_b", 32'(words_out_b), 32'd25);

    // Random soak.
    clr_win();
    soak_pushed = 0;
    for (int i = 0; i < 10000; i++) begin
      if ((wr_ptr + pend.size() - rd_ptr) < 6 && $urandom_range(1, 0) == 1) begin
        push(8'($urandom));
        soak_pushed++;
      end
      cycle($urandom_range(9, 0) != 0, $urandom_range(2, 0) != 0, $urandom_range(3, 0) == 0);
    end
    drain(100);
    chk("soak_all_delivered", 32'(n_fire_win), 32'(soak_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
